// File: rtl/nn_load_sequencer.sv
// Load/run controller feeding neural_network: weights then inputs from one valid/ready stream, then a compute pass.
// Optional NN_LOAD_CHECKSUM_EN adds load_checksum, the running sum of accepted beats.
module nn_load_sequencer #(
    parameter int BIT_SIZE    = 16,
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    localparam int NW = $clog2(LAYER_SIZE),
    localparam int LW = $clog2(LAYER_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BIT_SIZE-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
`ifdef NN_LOAD_CHECKSUM_EN
    output logic [BIT_SIZE-1:0] load_checksum,
`endif
    output logic                weight_write_enable,
    output logic                input_write_enable,
    output logic                input_select,
    output logic [LW-1:0]       layer,
    output logic [NW-1:0]       node,
    output logic [BIT_SIZE-1:0] x,
    output logic                busy,
    output logic                done
);
    localparam int TOT = LAYER_DEPTH * LAYER_SIZE;
    localparam int IW  = NW + LW;
    localparam logic [IW-1:0] IDX_LAST_W = IW'(TOT - 1);
    localparam logic [IW-1:0] IDX_LAST_X = IW'(LAYER_SIZE - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, RUN, DONE} state_t;
    state_t state, nxt;

    // One flat index serves all phases; node is its low bits, layer the high bits.
    logic [IW-1:0] idx;
    logic          beat;

    assign s_ready = (state == LOAD_W || state == LOAD_X) && !abort;
    assign beat    = s_valid && s_ready;
    assign busy    = (state == LOAD_W) || (state == LOAD_X) || (state == RUN);
    assign done    = (state == DONE);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = LOAD_W;
            LOAD_W:  if (beat && idx == IDX_LAST_W) nxt = LOAD_X;
            LOAD_X:  if (beat && idx == IDX_LAST_X) nxt = RUN;
            RUN:     if (idx == IDX_LAST_W) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx                 <= '0;
            weight_write_enable <= 1'b0;
            input_write_enable  <= 1'b0;
            input_select        <= 1'b1;
            layer               <= '0;
            node                <= '0;
            x                   <= '0;
        end else begin
            weight_write_enable <= 1'b0;
            input_write_enable  <= 1'b0;
            if (abort) begin
                idx          <= '0;
                layer        <= '0;
                node         <= '0;
                input_select <= 1'b1;
            end else begin
                case (state)
                    LOAD_W: if (beat) begin
                        weight_write_enable <= 1'b1;
                        x     <= s_data;
                        layer <= idx[IW-1:NW];
                        node  <= idx[NW-1:0];
                        idx   <= (idx == IDX_LAST_W) ? '0 : idx + 1'b1;
                    end
                    LOAD_X: if (beat) begin
                        input_write_enable <= 1'b1;
                        x     <= s_data;
                        layer <= '0;
                        node  <= idx[NW-1:0];
                        idx   <= (idx == IDX_LAST_X) ? '0 : idx + 1'b1;
                    end
                    RUN: begin
                        input_select <= 1'b0;
                        layer        <= idx[IW-1:NW];
                        node         <= idx[NW-1:0];
                        idx          <= (idx == IDX_LAST_W) ? '0 : idx + 1'b1;
                    end
                    default: begin
                        idx          <= '0;
                        input_select <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef NN_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           load_checksum <= '0;
        else if (abort)                     load_checksum <= '0;
        else if (state == IDLE && start)    load_checksum <= '0;
        else if (beat)                      load_checksum <= load_checksum + s_data;
    end
`endif
endmodule

// File: tb/tb_nn_load_sequencer.sv
// Directed bench for nn_load_sequencer: reset, full load, back-pressure, abort, start-in-run, optional checksum.
module tb_nn_load_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, abort, s_valid;
    logic [15:0] s_data;
    logic        s_ready, wwe, iwe, isel, busy, done;
    logic [1:0]  layer, node;
    logic [15:0] x;
`ifdef NN_LOAD_CHECKSUM_EN
    logic [15:0] load_checksum;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int dat [20];
    int wwe_cnt, iwe_cnt;

    always #5 clk = ~clk;

    nn_load_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef NN_LOAD_CHECKSUM_EN
        .load_checksum(load_checksum),
`endif
        .weight_write_enable(wwe), .input_write_enable(iwe), .input_select(isel),
        .layer(layer), .node(node), .x(x), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pack(input logic a, b, c, d, e, input logic [1:0] l, n);
        return {a, b, c, d, e, l, n};
    endfunction

    // Full start->done sequence; gap=0 streams every cycle, gap=1 inserts one bubble per beat.
    task automatic run_load(input int gap, input bit start_in_run);
        int P, L, n, r;
        logic v;
        logic ew, ei, es, eb, ed;
        logic [1:0] el, en;
        logic [15:0] ex;
        P = gap + 1;
        L = 1 + 19 * P;
        el = 2'd0; en = 2'd0; ex = x;
        wwe_cnt = 0; iwe_cnt = 0;
        start = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready", s_ready, 1);
        chk("start_busy", busy, 1);
        for (int e = 1; e <= L + 17; e++) begin
            v = ((e - 1) % P == 0) && (e <= L);
            s_valid = v;
            s_data  = v ? 16'(dat[(e - 1) / P]) : 16'hDEAD;
            start   = start_in_run && (e == L + 5);
            @(posedge clk); #1;
            start = 1'b0;
            ew = 0; ei = 0; es = 1; eb = 1; ed = 0;
            if (e <= L && v) begin
                n = (e - 1) / P;
                if (n < 16) begin ew = 1; el = 2'(n / 4); en = 2'(n % 4); end
                else        begin ei = 1; el = 2'd0;      en = 2'(n - 16); end
                ex = 16'(dat[n]);
            end else if (e <= L + 16 && e > L) begin
                r = e - L - 1;
                es = 0; el = 2'(r / 4); en = 2'(r % 4);
                eb = (e < L + 16); ed = (e == L + 16);
            end else if (e == L + 17) begin
                eb = 0;
            end
            if (wwe) wwe_cnt++;
            if (iwe) iwe_cnt++;
            chk($sformatf("ctl_e%0d", e), {23'd0, pack(wwe, iwe, isel, busy, done, layer, node)},
                {23'd0, pack(ew, ei, es, eb, ed, el, en)});
            chk($sformatf("x_e%0d", e), {16'd0, x}, {16'd0, ex});
        end
        s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("idle_quiet", {29'd0, done, wwe, busy}, 0);
        end
        s_valid = 1'b0;
        chk("wwe_count", wwe_cnt, 16);
        chk("iwe_count", iwe_cnt, 4);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        #12;
        chk("rst_ctl", {23'd0, pack(wwe, iwe, isel, busy, done, layer, node)}, {23'd0, pack(0, 0, 1, 0, 0, 0, 0)});
        chk("rst_x", x, 0);
        chk("rst_ready", s_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", s_ready, 0);

        for (int i = 0; i < 20; i++) dat[i] = i + 1;
        run_load(0, 1'b0);
        run_load(1, 1'b0);

        // abort after 7th weight beat
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            s_data = 16'(e + 50);
            @(posedge clk); #1;
        end
        chk("pre_abort_addr", {28'd0, layer, node}, {28'd0, 2'd1, 2'd2});
        abort = 1'b1; #1;
        chk("abort_ready", s_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ctl", {23'd0, pack(wwe, iwe, isel, busy, done, layer, node)}, {23'd0, pack(0, 0, 1, 0, 0, 0, 0)});
        chk("abort_idle_ready", s_ready, 0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        run_load(0, 1'b0);

        // start pulsed mid-run is ignored
        run_load(0, 1'b1);

        // async reset mid-load
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b0; #1;
        chk("midrst_ctl", {23'd0, pack(wwe, iwe, isel, busy, done, layer, node)}, {23'd0, pack(0, 0, 1, 0, 0, 0, 0)});
        chk("midrst_ready", s_ready, 0);
        chk("midrst_x", x, 0);
        s_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

`ifdef NN_LOAD_CHECKSUM_EN
        for (int i = 0; i < 16; i++) dat[i] = i + 1;
        dat[16] = 100; dat[17] = 200; dat[18] = 300; dat[19] = 400;
        run_load(0, 1'b0);
        chk("cksum_1136", load_checksum, 1136);
        for (int i = 0; i < 20; i++) dat[i] = 16'hFFFF;
        run_load(1, 1'b0);
        chk("cksum_wrap", load_checksum, 16'hFFEC);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
